// File: rtl/cmos_uploader.sv
// Streams the 4-bit CMOS array to the host as packed bytes.
// Each host byte is fetched as two nibble reads (low cell first), stalling on cmos_busy.
module cmos_uploader #(
  parameter int          BYTES = 512,
  parameter logic [7:0]  FILL  = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [9:0]  cmos_addr,
  output logic        cmos_req,
  input  logic        cmos_busy,
  input  logic [3:0]  cmos_data,
  output logic        upload_done
);

  typedef enum logic [2:0] {IDLE, REQ_LO, CAP_LO, REQ_HI, CAP_HI} state_t;

  state_t      state_q;
  logic [3:0]  lo_q;
  logic [7:0]  din_q;
  logic        wait_q, req_q;
  logic [9:0]  caddr_q;
  logic        up_q, done_q;
  logic        done_d;
  logic        in_range;

  assign in_range = (ioctl_addr < 25'(BYTES));
  assign done_d   = up_q & ~ioctl_upload;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      din_q   <= '0;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      caddr_q <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      up_q   <= ioctl_upload;
      done_q <= done_d;
      // Host abandoning the session aborts any fetch; din keeps the last good byte.
      if (state_q != IDLE && !ioctl_upload) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        wait_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ioctl_upload && ioctl_rd) begin
            if (in_range) begin
              caddr_q <= {ioctl_addr[8:0], 1'b0};
              req_q   <= 1'b1;
              wait_q  <= 1'b1;
              state_q <= REQ_LO;
            end else begin
              din_q   <= FILL;
            end
          end
          REQ_LO: if (!cmos_busy) begin
            req_q   <= 1'b0;
            state_q <= CAP_LO;
          end
          CAP_LO: begin
            lo_q    <= cmos_data;
            caddr_q <= caddr_q | 10'd1;
            req_q   <= 1'b1;
            state_q <= REQ_HI;
          end
          REQ_HI: if (!cmos_busy) begin
            req_q   <= 1'b0;
            state_q <= CAP_HI;
          end
          CAP_HI: begin
            din_q   <= {cmos_data, lo_q};
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign cmos_addr   = caddr_q;
  assign cmos_req    = req_q;
  assign upload_done = done_q;

endmodule

// File: tb/tb_cmos_uploader.sv
// Bench for cmos_uploader: CMOS responder with random stalls, byte scoreboard
// fed at strobe time and drained by a monitor watching wait/din.
module tb_cmos_uploader;

  localparam int         BYTES = 512;
  localparam logic [7:0] FILL  = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  cmos_addr;
  logic        cmos_req;
  logic        cmos_busy = 1'b0;
  logic [3:0]  cmos_data = '0;
  logic        upload_done;

  cmos_uploader #(.BYTES(BYTES), .FILL(FILL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .cmos_addr(cmos_addr), .cmos_req(cmos_req),
    .cmos_busy(cmos_busy), .cmos_data(cmos_data), .upload_done(upload_done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] mem [1024];
  logic [7:0] exp_q [$];
  logic [7:0] model_din = 8'h00;
  int busy_pct = 0;
  int busy_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CMOS side: data appears the cycle after a request is taken, junk otherwise.
  always begin
    logic       acc;
    logic [9:0] a;
    @(posedge clk_sys);
    acc = cmos_req && !cmos_busy;
    a   = cmos_addr;
    #2;
    cmos_data = acc ? mem[a] : 4'($urandom);
    if (busy_hold > 0) begin
      cmos_busy = 1'b1;
      busy_hold--;
    end else begin
      cmos_busy = ($urandom_range(99) < busy_pct);
    end
  end

  // Monitor: a fill byte lands one cycle after its strobe; a fetched byte when wait falls.
  logic mon_fill = 1'b0;
  logic wait_prev = 1'b0;
  always @(negedge clk_sys) begin
    logic [7:0] e;
    if (mon_fill || (wait_prev && !ioctl_wait && ioctl_upload && reset_n)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", 32'(ioctl_din), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_din", 32'(ioctl_din), 32'(e));
        check("sb_wait_low", 32'(ioctl_wait), 32'd0);
      end
    end
    mon_fill  = reset_n && ioctl_rd && ioctl_upload && !ioctl_wait && (ioctl_addr >= 25'(BYTES));
    wait_prev = ioctl_wait;
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference: a byte packs cells 2a (low) and 2a+1 (high); out of range reads FILL.
  function automatic logic [7:0] ref_byte(input int a);
    if (a >= BYTES) return FILL;
    return {mem[2*a+1], mem[2*a]};
  endfunction

  task automatic issue(input int a, input bit expect_done);
    ioctl_addr = 25'(a);
    ioctl_rd   = 1'b1;
    if (expect_done && ioctl_upload) begin
      exp_q.push_back(ref_byte(a));
      model_din = ref_byte(a);
    end
    cyc();
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_sys);
    while (ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (ioctl_wait) check("wait_timeout", 32'(ioctl_wait), 32'd0);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);

    // Reset values
    @(negedge clk_sys);
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req", 32'(cmos_req), 32'd0);
    check("rst_addr", 32'(cmos_addr), 32'd0);
    check("rst_done", 32'(upload_done), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Strobe with upload low is ignored
    issue(3, 1'b0);
    @(negedge clk_sys);
    check("noup_wait", 32'(ioctl_wait), 32'd0);
    check("noup_req", 32'(cmos_req), 32'd0);
    check("noup_din", 32'(ioctl_din), 32'(model_din));
    issue(600, 1'b0);
    @(negedge clk_sys);
    check("noup_fill_din", 32'(ioctl_din), 32'(model_din));
    cyc();

    ioctl_upload = 1'b1;
    cyc();

    // Basic fetch with exact latency, no stalls
    mem[10] = 4'h3; mem[11] = 4'hA;
    issue(5, 1'b1);
    @(negedge clk_sys);
    check("t1_wait", 32'(ioctl_wait), 32'd1);
    check("t1_req", 32'(cmos_req), 32'd1);
    check("t1_addr", 32'(cmos_addr), 32'd10);
    @(negedge clk_sys);
    check("t2_wait", 32'(ioctl_wait), 32'd1);
    check("t2_req", 32'(cmos_req), 32'd0);
    @(negedge clk_sys);
    check("t3_req", 32'(cmos_req), 32'd1);
    check("t3_addr", 32'(cmos_addr), 32'd11);
    @(negedge clk_sys);
    check("t4_wait", 32'(ioctl_wait), 32'd1);
    @(negedge clk_sys);
    check("t5_wait", 32'(ioctl_wait), 32'd0);
    check("t5_din", 32'(ioctl_din), 32'hA3);
    cyc();

    // Top of range and first out-of-range byte
    issue(511, 1'b1);
    @(negedge clk_sys);
    check("a511_lo_addr", 32'(cmos_addr), 32'd1022);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("a511_hi_addr", 32'(cmos_addr), 32'd1023);
    wait_idle();
    issue(512, 1'b1);
    @(negedge clk_sys);
    check("a512_din", 32'(ioctl_din), 32'(FILL));
    check("a512_wait", 32'(ioctl_wait), 32'd0);
    check("a512_req", 32'(cmos_req), 32'd0);
    @(negedge clk_sys);
    check("a512_req2", 32'(cmos_req), 32'd0);
    check("a512_wait2", 32'(ioctl_wait), 32'd0);
    cyc();

    // Three busy cycles while the high nibble is requested
    issue(5, 1'b1);
    cyc();
    cyc();
    busy_hold = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("stall_req", 32'(cmos_req), 32'd1);
      check("stall_addr", 32'(cmos_addr), 32'd11);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("stall_t7_wait", 32'(ioctl_wait), 32'd1);
    @(negedge clk_sys);
    check("stall_t8_wait", 32'(ioctl_wait), 32'd0);
    check("stall_t8_din", 32'(ioctl_din), 32'hA3);
    cyc();

    // Upload dropped while capturing the low nibble
    issue(100, 1'b0);
    cyc();
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_in_cap_wait", 32'(ioctl_wait), 32'd1);
    @(negedge clk_sys);
    check("abort_req", 32'(cmos_req), 32'd0);
    check("abort_wait", 32'(ioctl_wait), 32'd0);
    check("abort_din", 32'(ioctl_din), 32'(model_din));
    check("abort_done", 32'(upload_done), 32'd1);
    @(negedge clk_sys);
    check("abort_done_once", 32'(upload_done), 32'd0);
    cyc();
    ioctl_upload = 1'b1;
    cyc();

    // Reset asserted during the high-nibble request, upload stays high
    issue(7, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b0;
    #1;
    check("arst_din", 32'(ioctl_din), 32'h00);
    check("arst_wait", 32'(ioctl_wait), 32'd0);
    check("arst_req", 32'(cmos_req), 32'd0);
    check("arst_addr", 32'(cmos_addr), 32'd0);
    check("arst_done", 32'(upload_done), 32'd0);
    model_din = 8'h00;
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("rel_no_done", 32'(upload_done), 32'd0);
    end
    cyc();
    issue(7, 1'b1);
    wait_idle();

    // Full sweep over fresh random contents with random stalls
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    busy_pct = 30;
    for (int a = 0; a < BYTES; a++) begin
      issue(a, 1'b1);
      wait_idle();
      if (a % 64 == 63) begin
        issue(BYTES + int'($urandom_range(1000)), 1'b1);
        wait_idle();
      end
    end
    busy_pct = 0;

    repeat (4) cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
